ex_wb_sequencer: RTL and testbench

Execute-to-writeback stage that sits directly downstream of the ALU and consumes its 64-bit Result and 5-bit flag bus. It serialises results onto the single register-file write port. Long multiplies (UMULL/UMLAL/SMULL/SMLAL) need two beats, RdLo then RdHi; every other op needs one. It also owns the architectural status register: N, Z, C and V, plus a sticky Q. That register provides the carry fed back to the ALU's CarryIn.

---
 rtl/ex_wb_sequencer_pkg.sv | 36 +++
 rtl/ex_wb_sequencer_if.sv | 35 +++
 rtl/ex_wb_sequencer_status_reg.sv | 35 +++
 rtl/ex_wb_sequencer.sv | 79 +++++++
 tb/tb_ex_wb_sequencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_wb_sequencer_pkg.sv
// Shared definitions for the execute-to-writeback sequencer: sizes, ALU long-multiply
// encodings, flag bit positions and FSM state encoding.
package ex_wb_sequencer_pkg;

  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned ALUCONTROL_WIDTH = 6;
  localparam int unsigned REG_ADDR_WIDTH   = 4;
  localparam int unsigned FLAGS_WIDTH      = 5;

  localparam int unsigned FLAG_Q = 4;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_UMULL = 6'b101010;
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_UMLAL = 6'b101011;
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SMULL = 6'b101100;
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SMLAL = 6'b101101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HI   = 1'b1
  } state_e;

  // One register-file write beat
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } wb_beat_t;

  function automatic logic is_long_op(input logic [ALUCONTROL_WIDTH-1:0] op);
    return (op == ALU_UMULL) || (op == ALU_UMLAL) || (op == ALU_SMULL) || (op == ALU_SMLAL);
  endfunction

endpackage

// File: rtl/ex_wb_sequencer_if.sv
// ALU-result / register-file / status bus of the writeback sequencer.
interface ex_wb_sequencer_if;
  import ex_wb_sequencer_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [ALUCONTROL_WIDTH-1:0]   in_alu_control;
  logic [2*DATA_WIDTH-1:0]       in_result;
  logic [REG_ADDR_WIDTH-1:0]     in_rd_lo;
  logic [REG_ADDR_WIDTH-1:0]     in_rd_hi;
  logic                          in_reg_write;
  logic                          in_flag_write;
  logic [FLAGS_WIDTH-1:0]        in_alu_flags;
  logic                          q_clear;
  logic                          flush;
  logic                          rf_we;
  logic [REG_ADDR_WIDTH-1:0]     rf_wa;
  logic [DATA_WIDTH-1:0]         rf_wd;
  logic [FLAGS_WIDTH-1:0]        flags_q;
  logic                          carry_out;
  logic                          busy;

  modport master (
    output in_valid, in_alu_control, in_result, in_rd_lo, in_rd_hi,
           in_reg_write, in_flag_write, in_alu_flags, q_clear, flush,
    input  in_ready, rf_we, rf_wa, rf_wd, flags_q, carry_out, busy
  );

  modport slave (
    input  in_valid, in_alu_control, in_result, in_rd_lo, in_rd_hi,
           in_reg_write, in_flag_write, in_alu_flags, q_clear, flush,
    output in_ready, rf_we, rf_wa, rf_wd, flags_q, carry_out, busy
  );

endinterface

// File: rtl/ex_wb_sequencer_status_reg.sv
// Architectural status register {Q,N,Z,C,V}; Q is sticky and cleared only by q_clear.
module ex_wb_sequencer_status_reg
  import ex_wb_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flag_we,
  input  logic [FLAGS_WIDTH-1:0] alu_flags,
  input  logic                   q_clear,
  output logic [FLAGS_WIDTH-1:0] flags_q
);

  logic [FLAGS_WIDTH-1:0] flags_d;
  logic                   q_kept;

  // A same-edge Q set wins over q_clear
  always_comb begin
    flags_d = flags_q;
    q_kept  = flags_q[FLAG_Q] & ~q_clear;
    flags_d[FLAG_Q] = q_kept;
    if (flag_we) begin
      flags_d[FLAG_Q] = q_kept | alu_flags[FLAG_Q];
      flags_d[FLAG_N] = alu_flags[FLAG_N];
      flags_d[FLAG_Z] = alu_flags[FLAG_Z];
      flags_d[FLAG_C] = alu_flags[FLAG_C];
      flags_d[FLAG_V] = alu_flags[FLAG_V];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

endmodule

// File: rtl/ex_wb_sequencer.sv
// Serialises ALU results onto the single register-file write port; long multiplies
// take a second (RdHi) beat, during which upstream is stalled.
module ex_wb_sequencer
  import ex_wb_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  ex_wb_sequencer_if.slave   bus
);

  state_e   state_q, state_d;
  logic     rf_we_q, rf_we_d;
  wb_beat_t rf_q, rf_d;
  wb_beat_t hi_q, hi_d;
  logic     accept;
  logic [FLAGS_WIDTH-1:0] flags_q;

  assign bus.in_ready = (state_q == ST_IDLE);
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;

  always_comb begin
    state_d = state_q;
    rf_we_d = 1'b0;
    rf_d    = rf_q;
    hi_d    = hi_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && bus.in_reg_write) begin
          rf_we_d = 1'b1;
          rf_d    = '{addr: bus.in_rd_lo, data: bus.in_result[DATA_WIDTH-1:0]};
          if (is_long_op(bus.in_alu_control)) begin
            hi_d    = '{addr: bus.in_rd_hi, data: bus.in_result[2*DATA_WIDTH-1:DATA_WIDTH]};
            state_d = ST_HI;
          end
        end
      end
      ST_HI: begin
        // A flush here discards the pending hi word
        state_d = ST_IDLE;
        if (!bus.flush) begin
          rf_we_d = 1'b1;
          rf_d    = hi_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rf_we_q <= 1'b0;
      rf_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      rf_we_q <= rf_we_d;
      rf_q    <= rf_d;
      hi_q    <= hi_d;
    end
  end

  ex_wb_sequencer_status_reg u_status_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flag_we   (accept & bus.in_flag_write),
    .alu_flags (bus.in_alu_flags),
    .q_clear   (bus.q_clear),
    .flags_q   (flags_q)
  );

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_wa     = rf_q.addr;
  assign bus.rf_wd     = rf_q.data;
  assign bus.flags_q   = flags_q;
  assign bus.carry_out = flags_q[FLAG_C];
  assign bus.busy      = (state_q == ST_HI);

endmodule

// File: tb/tb_ex_wb_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_ex_wb_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_wb_sequencer_if bus();

  ex_wb_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } beat_t;

  // Reference model: writes still owed to the port, one per edge, plus the status register
  beat_t       owed[$];
  logic        m_we;
  logic [3:0]  m_wa;
  logic [31:0] m_wd;
  logic [4:0]  m_flags;

  function automatic logic model_long(input logic [5:0] op);
    return (op >= 6'b101010) && (op <= 6'b101101);
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_alu_control = '0; bus.in_result = '0;
    bus.in_rd_lo = '0; bus.in_rd_hi = '0; bus.in_reg_write = 0;
    bus.in_flag_write = 0; bus.in_alu_flags = '0; bus.q_clear = 0; bus.flush = 0;
  endtask

  task automatic drive_op(input logic [5:0] op, input logic [63:0] res, input logic [3:0] lo,
                          input logic [3:0] hi, input logic rw, input logic fw, input logic [4:0] fl);
    bus.in_valid = 1; bus.in_alu_control = op; bus.in_result = res; bus.in_rd_lo = lo;
    bus.in_rd_hi = hi; bus.in_reg_write = rw; bus.in_flag_write = fw; bus.in_alu_flags = fl;
  endtask

  task automatic model_reset();
    owed.delete();
    m_we = 0; m_wa = '0; m_wd = '0; m_flags = '0;
  endtask

  // Advances the model with the current inputs, then one clock edge; returns at edge+1
  task automatic tick();
    logic acc, qk;
    acc = bus.in_valid && (owed.size() == 0) && !bus.flush;
    if (bus.flush) owed.delete();
    else if (acc && bus.in_reg_write) begin
      owed.push_back('{a: bus.in_rd_lo, d: bus.in_result[31:0]});
      if (model_long(bus.in_alu_control)) owed.push_back('{a: bus.in_rd_hi, d: bus.in_result[63:32]});
    end
    qk = m_flags[4] && !bus.q_clear;
    if (acc && bus.in_flag_write) m_flags = {qk | bus.in_alu_flags[4], bus.in_alu_flags[3:0]};
    else m_flags[4] = qk;
    @(posedge clk);
    if (owed.size() != 0) begin
      beat_t b;
      b = owed.pop_front();
      m_we = 1; m_wa = b.a; m_wd = b.d;
    end else m_we = 0;
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", bus.rf_we); end
    checks++; if (bus.rf_wa !== 4'd0) begin errors++; $display("FAIL reset_wa got %0h exp 0", bus.rf_wa); end
    checks++; if (bus.rf_wd !== 32'd0) begin errors++; $display("FAIL reset_wd got %0h exp 0", bus.rf_wd); end
    checks++; if (bus.flags_q !== 5'd0) begin errors++; $display("FAIL reset_flags got %b exp 00000", bus.flags_q); end
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_ready got ready=%0b busy=%0b exp 1/0", bus.in_ready, bus.busy); end
  endtask

  task automatic test_single();
    drive_op(6'b100000, 64'h5, 4'd3, 4'd0, 1, 0, 5'b0);
    tick();
    idle_inputs();
    checks++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 4'd3, 32'h5}) begin errors++; $display("FAIL single_write got we=%0b wa=%0h wd=%0h exp 1/3/5", bus.rf_we, bus.rf_wa, bus.rf_wd); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b exp 1", bus.in_ready); end
    tick();
    checks++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b0, 4'd3, 32'h5}) begin errors++; $display("FAIL single_hold got we=%0b wa=%0h wd=%0h exp 0/3/5", bus.rf_we, bus.rf_wa, bus.rf_wd); end
  endtask

  task automatic test_long_back_to_back();
    drive_op(6'b101010, 64'h0000_0001_FFFF_FFFE, 4'd2, 4'd4, 1, 0, 5'b0);
    tick();
    drive_op(6'b100000, 64'h9, 4'd7, 4'd0, 1, 0, 5'b0);
    checks++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 4'd2, 32'hFFFF_FFFE}) begin errors++; $display("FAIL long_lo got we=%0b wa=%0h wd=%0h exp 1/2/fffffffe", bus.rf_we, bus.rf_wa, bus.rf_wd); end
    checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL long_stall got ready=%0b busy=%0b exp 0/1", bus.in_ready, bus.busy); end
    tick();
    checks++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 4'd4, 32'h1}) begin errors++; $display("FAIL long_hi got we=%0b wa=%0h wd=%0h exp 1/4/1", bus.rf_we, bus.rf_wa, bus.rf_wd); end
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL long_release got ready=%0b busy=%0b exp 1/0", bus.in_ready, bus.busy); end
    tick();
    idle_inputs();
    checks++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 4'd7, 32'h9}) begin errors++; $display("FAIL b2b_write got we=%0b wa=%0h wd=%0h exp 1/7/9", bus.rf_we, bus.rf_wa, bus.rf_wd); end
    tick();
  endtask

  task automatic test_flag_only();
    drive_op(6'b111000, 64'h0, 4'd1, 4'd0, 0, 1, 5'b00110);
    tick();
    idle_inputs();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL cmp_we got %0b exp 0", bus.rf_we); end
    checks++; if (bus.flags_q !== 5'b00110 || bus.carry_out !== 1'b1) begin errors++; $display("FAIL cmp_flags got %b c=%0b exp 00110 c=1", bus.flags_q, bus.carry_out); end
  endtask

  task automatic test_sticky_q();
    drive_op(6'b100001, 64'h0, 4'd0, 4'd0, 0, 1, 5'b10000);
    tick();
    checks++; if (bus.flags_q !== 5'b10000) begin errors++; $display("FAIL qadd_flags got %b exp 10000", bus.flags_q); end
    drive_op(6'b100000, 64'h0, 4'd0, 4'd0, 0, 1, 5'b01000);
    tick();
    idle_inputs();
    checks++; if (bus.flags_q !== 5'b11000) begin errors++; $display("FAIL q_sticky got %b exp 11000", bus.flags_q); end
    bus.q_clear = 1;
    tick();
    bus.q_clear = 0;
    checks++; if (bus.flags_q !== 5'b01000) begin errors++; $display("FAIL q_clear got %b exp 01000", bus.flags_q); end
    drive_op(6'b100001, 64'h0, 4'd0, 4'd0, 0, 1, 5'b10000);
    bus.q_clear = 1;
    tick();
    idle_inputs();
    checks++; if (bus.flags_q !== 5'b10000) begin errors++; $display("FAIL q_set_wins got %b exp 10000", bus.flags_q); end
  endtask

  task automatic test_flush();
    do_reset();
    drive_op(6'b101100, 64'hAAAA_BBBB_CCCC_DDDD, 4'd5, 4'd6, 1, 1, 5'b01010);
    tick();
    idle_inputs();
    checks++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 4'd5, 32'hCCCC_DDDD}) begin errors++; $display("FAIL smull_lo got we=%0b wa=%0h wd=%0h exp 1/5/ccccdddd", bus.rf_we, bus.rf_wa, bus.rf_wd); end
    checks++; if (bus.flags_q !== 5'b01010) begin errors++; $display("FAIL smull_flags got %b exp 01010", bus.flags_q); end
    bus.flush = 1;
    tick();
    checks++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b0, 4'd5, 32'hCCCC_DDDD}) begin errors++; $display("FAIL flush_hi got we=%0b wa=%0h wd=%0h exp 0/5/ccccdddd", bus.rf_we, bus.rf_wa, bus.rf_wd); end
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle got ready=%0b busy=%0b exp 1/0", bus.in_ready, bus.busy); end
    drive_op(6'b100000, 64'h77, 4'd8, 4'd0, 1, 1, 5'b11111);
    tick();
    idle_inputs();
    checks++; if (bus.rf_we !== 1'b0 || bus.flags_q !== 5'b01010) begin errors++; $display("FAIL flush_input got we=%0b flags=%b exp 0/01010", bus.rf_we, bus.flags_q); end
    tick();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL flush_no_late got %0b exp 0", bus.rf_we); end
  endtask

  task automatic test_async_reset_hi();
    drive_op(6'b101011, 64'h1234_5678_9ABC_DEF0, 4'd1, 4'd9, 1, 1, 5'b00001);
    tick();
    idle_inputs();
    checks++; if ({bus.busy, bus.rf_wa, bus.rf_wd} !== {1'b1, 4'd1, 32'h9ABC_DEF0}) begin errors++; $display("FAIL umlal_lo got busy=%0b wa=%0h wd=%0h exp 1/1/9abcdef0", bus.busy, bus.rf_wa, bus.rf_wd); end
    #2 rst_n = 0;
    #1;
    checks++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd, bus.flags_q, bus.busy} !== 43'd0) begin errors++; $display("FAIL async_clear got we=%0b wa=%0h wd=%0h flags=%b busy=%0b exp all 0", bus.rf_we, bus.rf_wa, bus.rf_wd, bus.flags_q, bus.busy); end
    @(posedge clk); #1 rst_n = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.rf_we !== 1'b0 || bus.rf_wa !== 4'd0) begin errors++; $display("FAIL post_reset_%0d got we=%0b wa=%0h exp 0/0", i, bus.rf_we, bus.rf_wa); end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    ops = '{6'b100000, 6'b100001, 6'b111000, 6'b000001, 6'b101010, 6'b101011, 6'b101100, 6'b101101};
    for (int i = 0; i < 400; i++) begin
      bus.in_valid       = ($urandom_range(0, 9) < 7);
      bus.in_alu_control = ops[$urandom_range(0, 7)];
      bus.in_result      = {$urandom, $urandom};
      bus.in_rd_lo       = 4'($urandom);
      bus.in_rd_hi       = 4'($urandom);
      bus.in_reg_write   = ($urandom_range(0, 3) != 0);
      bus.in_flag_write  = $urandom_range(0, 1) != 0;
      bus.in_alu_flags   = 5'($urandom);
      bus.q_clear        = ($urandom_range(0, 9) == 0);
      bus.flush          = ($urandom_range(0, 9) == 0);
      #1;
      checks++; if (bus.in_ready !== (owed.size() == 0) || bus.busy !== (owed.size() != 0)) begin errors++; $display("FAIL rand_ready_%0d got ready=%0b busy=%0b exp ready=%0b", i, bus.in_ready, bus.busy, owed.size() == 0); end
      tick();
      checks++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {m_we, m_wa, m_wd}) begin errors++; $display("FAIL rand_port_%0d got we=%0b wa=%0h wd=%0h exp %0b/%0h/%0h", i, bus.rf_we, bus.rf_wa, bus.rf_wd, m_we, m_wa, m_wd); end
      checks++; if (bus.flags_q !== m_flags || bus.carry_out !== m_flags[1]) begin errors++; $display("FAIL rand_flags_%0d got %b c=%0b exp %b", i, bus.flags_q, bus.carry_out, m_flags); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_single();
    test_long_back_to_back();
    test_flag_only();
    test_sticky_q();
    test_flush();
    test_async_reset_hi();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
